// File: rtl/uart_pkg.sv
// Shared UART definitions (state encoding and line levels) used by both TX and RX.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_e;

   localparam int unsigned UART_DATA_BITS = 8;
   localparam logic        UART_START_BIT = 1'b0;
   localparam logic        UART_STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: emits a one-cycle bit_tick_o on the last clock of every bit period.
module uart_baud_gen #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clear_i,
   output logic bit_tick_o
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign bit_tick_o = (cnt_q == CW'(CLKS_PER_BIT - 1));

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear_i || bit_tick_o) cnt_d = '0;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits MSB first, optional even parity, STOP_BITS stop bits.
// Parity is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       d_out,
   output logic       busy
);

   localparam logic [2:0] BIT_LAST  = 3'(UART_DATA_BITS - 1);
   localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

   uart_state_e state_q, state_d;
   logic [7:0]  shreg_q, shreg_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic        stop_cnt_q, stop_cnt_d;
   logic        d_out_q, d_out_d;
   logic        accept, bit_tick;
`ifdef UART_TX_PARITY_EN
   logic        parity_q, parity_d;
`endif

   assign tx_ready = (state_q == IDLE) && !reset;
   assign accept   = tx_valid && tx_ready;
   assign busy     = (state_q != IDLE);
   assign d_out    = d_out_q;

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk_i      (clk),
      .reset_i    (reset),
      .clear_i    (accept),
      .bit_tick_o (bit_tick)
   );

   // d_out_d is the level of the bit being entered, so the line is registered without lag.
   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      d_out_d    = d_out_q;
`ifdef UART_TX_PARITY_EN
      parity_d   = parity_q;
`endif
      case (state_q)
         IDLE: begin
            d_out_d = UART_STOP_BIT;
            if (accept) begin
               state_d    = START;
               shreg_d    = tx_data;
               bit_cnt_d  = '0;
               stop_cnt_d = '0;
               d_out_d    = UART_START_BIT;
`ifdef UART_TX_PARITY_EN
               parity_d   = ^tx_data;
`endif
            end
         end
         START: begin
            if (bit_tick) begin
               state_d = DATA;
               d_out_d = shreg_q[7];
            end
         end
         DATA: begin
            if (bit_tick) begin
               if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
                  d_out_d = parity_q;
`else
                  state_d = STOP;
                  d_out_d = UART_STOP_BIT;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  shreg_d   = {shreg_q[6:0], 1'b0};
                  d_out_d   = shreg_q[6];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_tick) begin
               state_d = STOP;
               d_out_d = UART_STOP_BIT;
            end
         end
`endif
         STOP: begin
            if (bit_tick) begin
               if (stop_cnt_q == STOP_LAST) state_d = IDLE;
               else                         stop_cnt_d = stop_cnt_q + 1'b1;
               d_out_d = UART_STOP_BIT;
            end
         end
         default: begin
            state_d = IDLE;
            d_out_d = UART_STOP_BIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= '0;
         d_out_q    <= UART_STOP_BIT;
`ifdef UART_TX_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         d_out_q    <= d_out_d;
`ifdef UART_TX_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

endmodule
